// File: rtl/clk_enable_gen.sv
// Multi-channel fractional clock-enable generator built on phase accumulators, with a lock flag after a settle period.
// Optional build macro CLK_ENABLE_GEN_LOCK_GATE_EN forces ce_out/clk_div_out low while unlocked.
module clk_enable_gen #(
  parameter int NUM_CH      = 2,
  parameter int ACC_W       = 16,
  parameter int LOCK_CYCLES = 16,
  parameter logic [ACC_W-1:0] INIT_INC = {1'b1, {(ACC_W-1){1'b0}}}
) (
  input  logic                     refclk,
  input  logic                     rst_n,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [NUM_CH*ACC_W-1:0]  cfg_inc,
  input  logic [NUM_CH*ACC_W-1:0]  cfg_phase,
  output logic [NUM_CH-1:0]        ce_out,
  output logic [NUM_CH-1:0]        clk_div_out,
  output logic                     locked,
  output logic [1:0]               dbg_state
);

  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_RST    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t                         r_state;
  logic [CNT_W-1:0]               r_cnt;
  logic                           r_ready;
  logic                           r_locked;
  logic [NUM_CH-1:0][ACC_W-1:0]   r_acc;
  logic [NUM_CH-1:0][ACC_W-1:0]   r_inc;
  logic [NUM_CH-1:0]              r_ce;
  logic [NUM_CH-1:0]              r_div;

  logic                           w_xfer;
  logic                           w_lock_nxt;
  logic [NUM_CH-1:0][ACC_W:0]     w_sum;

  // Handshake: a config word transfers on any rising edge where cfg_valid and cfg_ready are both high.
  always_comb begin
    w_xfer     = cfg_valid && r_ready;
    w_lock_nxt = r_locked || ((r_state == ST_SETTLE) && (r_cnt == '0));
    for (int c = 0; c < NUM_CH; c++) begin
      w_sum[c] = {1'b0, r_acc[c]} + {1'b0, r_inc[c]};
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_RST;
      r_cnt    <= '0;
      r_ready  <= 1'b0;
      r_locked <= 1'b0;
      r_acc    <= '0;
      r_inc    <= {NUM_CH{INIT_INC}};
      r_ce     <= '0;
      r_div    <= '0;
    end else begin
      case (r_state)
        ST_RST: begin
          r_state <= ST_SETTLE;
          r_cnt   <= CNT_W'(LOCK_CYCLES - 1);
          r_ready <= 1'b1;
        end
        default: begin
          if (w_xfer) begin
            r_state  <= ST_SETTLE;
            r_cnt    <= CNT_W'(LOCK_CYCLES - 1);
            r_locked <= 1'b0;
            r_ce     <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
              r_inc[c] <= cfg_inc[c*ACC_W +: ACC_W];
              r_acc[c] <= cfg_phase[c*ACC_W +: ACC_W];
`ifdef CLK_ENABLE_GEN_LOCK_GATE_EN
              r_div[c] <= 1'b0;
`else
              r_div[c] <= cfg_phase[c*ACC_W + ACC_W - 1];
`endif
            end
          end else begin
            if (r_state == ST_SETTLE) begin
              if (r_cnt == '0) begin
                r_state  <= ST_LOCKED;
                r_locked <= 1'b1;
              end else begin
                r_cnt <= r_cnt - 1'b1;
              end
            end
            // Accumulators free-run regardless of gating so phase is intact at lock.
            for (int c = 0; c < NUM_CH; c++) begin
              r_acc[c] <= w_sum[c][ACC_W-1:0];
`ifdef CLK_ENABLE_GEN_LOCK_GATE_EN
              r_ce[c]  <= w_sum[c][ACC_W] & w_lock_nxt;
              r_div[c] <= w_sum[c][ACC_W-1] & w_lock_nxt;
`else
              r_ce[c]  <= w_sum[c][ACC_W];
              r_div[c] <= w_sum[c][ACC_W-1];
`endif
            end
          end
        end
      endcase
    end
  end

  assign cfg_ready   = r_ready;
  assign ce_out      = r_ce;
  assign clk_div_out = r_div;
  assign locked      = r_locked;
  assign dbg_state   = r_state;

endmodule
